sc_debounce_pulse: RTL and testbench

Conditions a raw mechanical pushbutton into a clean, single-cycle, active-low count-enable pulse. It sits directly upstream of the 8-bit up-counter and drives its active-low upcount input, so one physical press produces exactly one increment. Also exports a debounced level for status LEDs.

---
 rtl/sc_debounce_pkg.sv | 10 +
 rtl/sc_debounce_pulse_if.sv | 17 +
 rtl/sc_sync2.sv | 18 +
 rtl/sc_debounce_pulse.sv | 87 ++++++++
 tb/tb_sc_debounce_pulse.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/sc_debounce_pkg.sv
// sc_debounce_pkg: shared state encoding and pulse polarity for the pushbutton debouncer.
package sc_debounce_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM_PRESS = 2'd1,
    PRESSED   = 2'd2,
    ARM_REL   = 2'd3
  } state_e;
  localparam logic PULSE_ACTIVE = 1'b0;
endpackage

// File: rtl/sc_debounce_pulse_if.sv
// sc_debounce_pulse_if: raw key in, debounced pulse and level out.
interface sc_debounce_pulse_if;
  import sc_debounce_pkg::*;
  logic SC_DEBOUNCE_button_InLow;
  logic SC_DEBOUNCE_pulse_OutLow;
  logic SC_DEBOUNCE_level_OutHigh;
  modport master (
    output SC_DEBOUNCE_button_InLow,
    input  SC_DEBOUNCE_pulse_OutLow,
    input  SC_DEBOUNCE_level_OutHigh
  );
  modport slave (
    input  SC_DEBOUNCE_button_InLow,
    output SC_DEBOUNCE_pulse_OutLow,
    output SC_DEBOUNCE_level_OutHigh
  );
endinterface

// File: rtl/sc_sync2.sv
// sc_sync2: two-flop synchronizer for active-low board keys; resets to released (1).
module sc_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic sync_q
);
  logic meta_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
    end
  end
endmodule

// File: rtl/sc_debounce_pulse.sv
// sc_debounce_pulse: debounces a raw pushbutton into one active-low pulse per press plus a level.
module sc_debounce_pulse
  import sc_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
  input logic               SC_DEBOUNCE_CLOCK_50,
  input logic               SC_DEBOUNCE_RESET_InLow,
  sc_debounce_pulse_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  logic                 sync_q;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pulse_q, pulse_d;
  logic                 level_q, level_d;
  sc_sync2 u_sync (
    .clk    (SC_DEBOUNCE_CLOCK_50),
    .rst_n  (SC_DEBOUNCE_RESET_InLow),
    .d_in   (bus.SC_DEBOUNCE_button_InLow),
    .sync_q (sync_q)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!sync_q) begin
          state_d = ARM_PRESS;
          cnt_d   = CNT_ONE;
        end
      end
      ARM_PRESS: begin
        if (sync_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (sync_q) begin
          state_d = ARM_REL;
          cnt_d   = CNT_ONE;
        end
      end
      ARM_REL: begin
        if (!sync_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // The pulse fires only on the single accepting transition, never while held.
    pulse_d = (state_q == ARM_PRESS && !sync_q && cnt_q == CNT_MAX) ? PULSE_ACTIVE : ~PULSE_ACTIVE;
    level_d = (state_d == PRESSED) || (state_d == ARM_REL);
  end
  always_ff @(posedge SC_DEBOUNCE_CLOCK_50 or negedge SC_DEBOUNCE_RESET_InLow) begin
    if (!SC_DEBOUNCE_RESET_InLow) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= ~PULSE_ACTIVE;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end
  assign bus.SC_DEBOUNCE_pulse_OutLow  = pulse_q;
  assign bus.SC_DEBOUNCE_level_OutHigh = level_q;
endmodule

// File: tb/tb_sc_debounce_pulse.sv
// tb_sc_debounce_pulse: directed scenarios for the debouncer with D=4 and a downstream 8-bit counter model.
module tb_sc_debounce_pulse;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] cnt8 = 8'h00;
  int total = 0;
  int bad = 0;
  sc_debounce_pulse_if bus ();
  sc_debounce_pulse #(.DEBOUNCE_CYCLES(D)) dut (
    .SC_DEBOUNCE_CLOCK_50    (clk),
    .SC_DEBOUNCE_RESET_InLow (rst_n),
    .bus                     (bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.SC_DEBOUNCE_pulse_OutLow === 1'b0) cnt8 = cnt8 + 8'h01;
  endtask
  task automatic idle_release(input int n);
    bus.SC_DEBOUNCE_button_InLow = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic test_reset();
    bus.SC_DEBOUNCE_button_InLow = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if (bus.SC_DEBOUNCE_pulse_OutLow !== 1'b1) begin
      bad++;
      $display("FAIL reset_pulse got=%b want=1", bus.SC_DEBOUNCE_pulse_OutLow);
    end
    total++;
    if (bus.SC_DEBOUNCE_level_OutHigh !== 1'b0) begin
      bad++;
      $display("FAIL reset_level got=%b want=0", bus.SC_DEBOUNCE_level_OutHigh);
    end
    rst_n = 1'b1;
    idle_release(4);
    cnt8 = 8'h00;
  endtask
  task automatic test_clean_press();
    cnt8 = 8'h00;
    bus.SC_DEBOUNCE_button_InLow = 1'b0;
    for (int k = 1; k <= D + 4; k++) begin
      tick();
      total++;
      if (bus.SC_DEBOUNCE_pulse_OutLow !== ((k == D + 2) ? 1'b0 : 1'b1)) begin
        bad++;
        $display("FAIL press_pulse edge=%0d got=%b want=%b", k, bus.SC_DEBOUNCE_pulse_OutLow, (k == D + 2) ? 1'b0 : 1'b1);
      end
      total++;
      if (bus.SC_DEBOUNCE_level_OutHigh !== ((k >= D + 2) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL press_level edge=%0d got=%b want=%b", k, bus.SC_DEBOUNCE_level_OutHigh, (k >= D + 2) ? 1'b1 : 1'b0);
      end
    end
    total++;
    if (cnt8 !== 8'h01) begin
      bad++;
      $display("FAIL press_counter got=%h want=01", cnt8);
    end
    bus.SC_DEBOUNCE_button_InLow = 1'b1;
    for (int k = 1; k <= D + 4; k++) begin
      tick();
      total++;
      if (bus.SC_DEBOUNCE_level_OutHigh !== ((k >= D + 2) ? 1'b0 : 1'b1)) begin
        bad++;
        $display("FAIL release_level edge=%0d got=%b want=%b", k, bus.SC_DEBOUNCE_level_OutHigh, (k >= D + 2) ? 1'b0 : 1'b1);
      end
    end
    total++;
    if (cnt8 !== 8'h01) begin
      bad++;
      $display("FAIL release_counter got=%h want=01", cnt8);
    end
  endtask
  task automatic test_bounce();
    logic [4:0] pat;
    int level_hits;
    pat = 5'b10010;
    level_hits = 0;
    cnt8 = 8'h00;
    for (int i = 0; i < 5; i++) begin
      bus.SC_DEBOUNCE_button_InLow = pat[i];
      tick();
      if (bus.SC_DEBOUNCE_level_OutHigh !== 1'b0) level_hits++;
    end
    bus.SC_DEBOUNCE_button_InLow = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.SC_DEBOUNCE_level_OutHigh !== 1'b0) level_hits++;
    end
    total++;
    if (cnt8 !== 8'h00) begin
      bad++;
      $display("FAIL bounce_counter got=%h want=00", cnt8);
    end
    total++;
    if (level_hits != 0) begin
      bad++;
      $display("FAIL bounce_level high_cycles=%0d want=0", level_hits);
    end
  endtask
  task automatic test_long_hold();
    int level_low;
    level_low = 0;
    cnt8 = 8'h00;
    bus.SC_DEBOUNCE_button_InLow = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k >= D + 2 && bus.SC_DEBOUNCE_level_OutHigh !== 1'b1) level_low++;
    end
    total++;
    if (cnt8 !== 8'h01) begin
      bad++;
      $display("FAIL hold_pulses got=%0d want=1", cnt8);
    end
    total++;
    if (level_low != 0) begin
      bad++;
      $display("FAIL hold_level low_cycles=%0d want=0", level_low);
    end
    idle_release(D + 6);
  endtask
  task automatic test_release_bounce();
    int level_low;
    level_low = 0;
    bus.SC_DEBOUNCE_button_InLow = 1'b0;
    for (int k = 0; k < D + 4; k++) tick();
    cnt8 = 8'h00;
    bus.SC_DEBOUNCE_button_InLow = 1'b1;
    tick();
    if (bus.SC_DEBOUNCE_level_OutHigh !== 1'b1) level_low++;
    tick();
    if (bus.SC_DEBOUNCE_level_OutHigh !== 1'b1) level_low++;
    bus.SC_DEBOUNCE_button_InLow = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.SC_DEBOUNCE_level_OutHigh !== 1'b1) level_low++;
    end
    total++;
    if (cnt8 !== 8'h00) begin
      bad++;
      $display("FAIL relbounce_pulses got=%0d want=0", cnt8);
    end
    total++;
    if (level_low != 0) begin
      bad++;
      $display("FAIL relbounce_level low_cycles=%0d want=0", level_low);
    end
    total++;
    if (dut.state_q !== sc_debounce_pkg::PRESSED) begin
      bad++;
      $display("FAIL relbounce_state got=%0d want=%0d", dut.state_q, sc_debounce_pkg::PRESSED);
    end
    idle_release(D + 6);
  endtask
  task automatic test_ten_presses();
    cnt8 = 8'h00;
    for (int p = 0; p < 10; p++) begin
      bus.SC_DEBOUNCE_button_InLow = 1'b0;
      for (int k = 0; k < 12; k++) tick();
      bus.SC_DEBOUNCE_button_InLow = 1'b1;
      for (int k = 0; k < 12; k++) tick();
    end
    total++;
    if (cnt8 !== 8'h0A) begin
      bad++;
      $display("FAIL ten_counter got=%h want=0a", cnt8);
    end
  endtask
  task automatic test_reset_mid();
    bus.SC_DEBOUNCE_button_InLow = 1'b0;
    for (int k = 0; k < D + 2; k++) tick();
    total++;
    if (bus.SC_DEBOUNCE_pulse_OutLow !== 1'b0) begin
      bad++;
      $display("FAIL mid_prepulse got=%b want=0", bus.SC_DEBOUNCE_pulse_OutLow);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.SC_DEBOUNCE_pulse_OutLow !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_pulse got=%b want=1", bus.SC_DEBOUNCE_pulse_OutLow);
    end
    total++;
    if (bus.SC_DEBOUNCE_level_OutHigh !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_level got=%b want=0", bus.SC_DEBOUNCE_level_OutHigh);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= D + 4; k++) begin
      tick();
      total++;
      if (bus.SC_DEBOUNCE_pulse_OutLow !== ((k == D + 2) ? 1'b0 : 1'b1)) begin
        bad++;
        $display("FAIL mid_repress edge=%0d got=%b want=%b", k, bus.SC_DEBOUNCE_pulse_OutLow, (k == D + 2) ? 1'b0 : 1'b1);
      end
    end
    idle_release(D + 6);
  endtask
  initial begin
    bus.SC_DEBOUNCE_button_InLow = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_release_bounce();
    test_ten_presses();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
